// File: rtl/padding_top_core.sv
// -----------------------------------------------------------------------------
// padding_top_core
//
// Builds a zero-padded 3-row sliding window for a 3x3 image kernel. Each
// incoming 416-pixel row (8-bit pixels) is widened to 418 pixels by adding a
// zero pixel on the left (index 0) and on the right (index 417). The window
// holds three such rows per colour channel: row0 = oldest (top), row1 = middle,
// row2 = newest (bottom).
//
// Row index 0 starts a frame: rows 0/1 are cleared (top padding) and the
// padded input lands in row2. Indices 1..415 shift the window by one row.
// Index 416 shifts in an all-zero row (bottom padding). Higher indices and
// stalled (wait_en) or idle (en=0) cycles leave the window untouched.
//
// Optional feature macro: PADDING_VALID_EN -- adds the win_valid output, high
// when the window is centred on a real image row.
//
// Ports
//   clk                     system clock, rising edge
//   reset                   asynchronous reset, active low
//   en                      input row presented this cycle
//   wait_en                 downstream stall, overrides en
//   count[8:0]              row index of the presented row (416 = flush)
//   R/G/B_input[3327:0]     one input row per channel, pixel i at [8i+7:8i]
//   R/G/B_row0..2[3343:0]   registered padded window rows per channel
//   win_valid               (PADDING_VALID_EN only) window centred on image
// -----------------------------------------------------------------------------
module padding_top_core #(
  parameter int DATA_W = 8,
  parameter int PIXELS = 416,
  parameter int ROWS   = 416
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           wait_en,
  input  logic [8:0]                     count,
  input  logic [DATA_W*PIXELS-1:0]       R_input,
  input  logic [DATA_W*PIXELS-1:0]       G_input,
  input  logic [DATA_W*PIXELS-1:0]       B_input,
  output logic [DATA_W*(PIXELS+2)-1:0]   R_row0,
  output logic [DATA_W*(PIXELS+2)-1:0]   G_row0,
  output logic [DATA_W*(PIXELS+2)-1:0]   B_row0,
  output logic [DATA_W*(PIXELS+2)-1:0]   R_row1,
  output logic [DATA_W*(PIXELS+2)-1:0]   G_row1,
  output logic [DATA_W*(PIXELS+2)-1:0]   B_row1,
  output logic [DATA_W*(PIXELS+2)-1:0]   R_row2,
  output logic [DATA_W*(PIXELS+2)-1:0]   G_row2,
  output logic [DATA_W*(PIXELS+2)-1:0]   B_row2
`ifdef PADDING_VALID_EN
  ,
  output logic                           win_valid
`endif
);

  localparam int         IN_W      = DATA_W * PIXELS;
  localparam int         OUT_W     = DATA_W * (PIXELS + 2);
  localparam logic [8:0] LAST_ROW  = 9'(ROWS - 1);
  localparam logic [8:0] FLUSH_ROW = 9'(ROWS);

  // Left/right zero pixel around the raw row.
  function automatic logic [OUT_W-1:0] pad_row(input logic [IN_W-1:0] x);
    return {{DATA_W{1'b0}}, x, {DATA_W{1'b0}}};
  endfunction

  logic             accept;
  logic             load;
  logic             shift;
  logic [OUT_W-1:0] r_new;
  logic [OUT_W-1:0] g_new;
  logic [OUT_W-1:0] b_new;

  // Decode: stall beats en; indices past the flush row are ignored.
  always_comb begin
    accept = en && !wait_en;
    load   = accept && (count == 9'd0);
    shift  = accept && (count != 9'd0) && (count <= FLUSH_ROW);
    // The flush row brings in zeros regardless of the input bus.
    r_new  = (count > LAST_ROW) ? '0 : pad_row(R_input);
    g_new  = (count > LAST_ROW) ? '0 : pad_row(G_input);
    b_new  = (count > LAST_ROW) ? '0 : pad_row(B_input);
  end

  // ---- window registers: one clock from accepting edge to outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      R_row0 <= '0;
      G_row0 <= '0;
      B_row0 <= '0;
      R_row1 <= '0;
      G_row1 <= '0;
      B_row1 <= '0;
      R_row2 <= '0;
      G_row2 <= '0;
      B_row2 <= '0;
    end else if (load) begin
      R_row0 <= '0;
      G_row0 <= '0;
      B_row0 <= '0;
      R_row1 <= '0;
      G_row1 <= '0;
      B_row1 <= '0;
      R_row2 <= r_new;
      G_row2 <= g_new;
      B_row2 <= b_new;
    end else if (shift) begin
      R_row0 <= R_row1;
      G_row0 <= G_row1;
      B_row0 <= B_row1;
      R_row1 <= R_row2;
      G_row1 <= G_row2;
      B_row1 <= B_row2;
      R_row2 <= r_new;
      G_row2 <= g_new;
      B_row2 <= b_new;
    end
  end

`ifdef PADDING_VALID_EN
  // After a load the window centre (row1) is top padding; after any shift
  // up to the flush row the centre is a real image row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_valid <= 1'b0;
    end else if (load) begin
      win_valid <= 1'b0;
    end else if (shift) begin
      win_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_padding_top_core.sv
module tb_padding_top_core;

  localparam int IW = 3328;
  localparam int OW = 3344;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          wait_en;
  logic [8:0]    count;
  logic [IW-1:0] r_in, g_in, b_in;
  logic [OW-1:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
`ifdef PADDING_VALID_EN
  logic          win_valid;
  logic          exp_valid;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference window per channel: win[ch][0] = oldest row, win[ch][2] = newest.
  logic [OW-1:0] win [3][3];
  // Observed rows, index = row*3 + channel (channel 0=R, 1=G, 2=B).
  logic [OW-1:0] obs [9];

  always #5 clk = ~clk;

  padding_top_core dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .wait_en (wait_en),
    .count   (count),
    .R_input (r_in),
    .G_input (g_in),
    .B_input (b_in),
    .R_row0  (r0),
    .G_row0  (g0),
    .B_row0  (b0),
    .R_row1  (r1),
    .G_row1  (g1),
    .B_row1  (b1),
    .R_row2  (r2),
    .G_row2  (g2),
    .B_row2  (b2)
`ifdef PADDING_VALID_EN
    ,
    .win_valid (win_valid)
`endif
  );

  always_comb begin
    obs[0] = r0; obs[1] = g0; obs[2] = b0;
    obs[3] = r1; obs[4] = g1; obs[5] = b1;
    obs[6] = r2; obs[7] = g2; obs[8] = b2;
  end

  // Padded row built pixel by pixel: input pixel i becomes padded pixel i+1.
  function automatic logic [OW-1:0] pad_row(input logic [IW-1:0] x);
    logic [OW-1:0] p;
    p = '0;
    for (int i = 0; i < 416; i++) p[8*(i+1) +: 8] = x[8*i +: 8];
    return p;
  endfunction

  function automatic logic [IW-1:0] rand_row();
    logic [IW-1:0] x;
    for (int w = 0; w < IW/32; w++) x[32*w +: 32] = $urandom;
    return x;
  endfunction

  // Index of the first differing pixel, for diagnostics.
  function automatic int first_diff(input logic [OW-1:0] a, input logic [OW-1:0] b);
    for (int i = 0; i < 418; i++) if (a[8*i +: 8] !== b[8*i +: 8]) return i;
    return 0;
  endfunction

  task automatic model_clear();
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 3; r++) win[ch][r] = '0;
`ifdef PADDING_VALID_EN
    exp_valid = 1'b0;
`endif
  endtask

  // Drive one cycle (reset assumed released) and advance the reference model.
  task automatic apply(input logic e, input logic w, input logic [8:0] c,
                       input logic [IW-1:0] xr, input logic [IW-1:0] xg,
                       input logic [IW-1:0] xb);
    logic [IW-1:0] x [3];
    en = e; wait_en = w; count = c; r_in = xr; g_in = xg; b_in = xb;
    x[0] = xr; x[1] = xg; x[2] = xb;
    @(posedge clk); #1;
    if (e && !w && c <= 9'd416) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (c == 9'd0) begin
          win[ch][0] = '0;
          win[ch][1] = '0;
          win[ch][2] = pad_row(x[ch]);
        end else begin
          win[ch][0] = win[ch][1];
          win[ch][1] = win[ch][2];
          win[ch][2] = (c == 9'd416) ? '0 : pad_row(x[ch]);
        end
      end
`ifdef PADDING_VALID_EN
      exp_valid = (c != 9'd0);
`endif
    end
  endtask

  task automatic test_reset();
    logic [OW-1:0] req;
    reset = 1'b0; en = 1'b1; wait_en = 1'b0; count = 9'd0;
    r_in = rand_row() | 1; g_in = rand_row() | 1; b_in = rand_row() | 1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    req = '0;
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (obs[k] !== req) begin
        miscompares++;
        $display("FAIL reset_hold row%0d ch%0d: pixel %0d actual %h required %h", k/3, k%3,
                 first_diff(obs[k], req), obs[k][8*first_diff(obs[k], req) +: 8],
                 req[8*first_diff(obs[k], req) +: 8]);
      end
    end
    reset = 1'b1;
    apply(1'b0, 1'b0, 9'd0, rand_row(), rand_row(), rand_row());
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (obs[k] !== req) begin
        miscompares++;
        $display("FAIL reset_release row%0d ch%0d: pixel %0d actual %h required %h", k/3, k%3,
                 first_diff(obs[k], req), obs[k][8*first_diff(obs[k], req) +: 8],
                 req[8*first_diff(obs[k], req) +: 8]);
      end
    end
`ifdef PADDING_VALID_EN
    vectors++;
    if (win_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: actual %b required 0", win_valid);
    end
`endif
  endtask

  task automatic test_row_sequence();
    logic [OW-1:0] req;
    apply(1'b1, 1'b0, 9'd0, IW'(1), IW'(1), IW'(1));
    apply(1'b1, 1'b0, 9'd1, IW'(2), IW'(2), IW'(2));
    apply(1'b1, 1'b0, 9'd2, IW'(3), IW'(3), IW'(3));
    for (int k = 0; k < 9; k++) begin
      req = OW'((k/3 + 1) * 256);
      vectors++;
      if (obs[k] !== req) begin
        miscompares++;
        $display("FAIL row_sequence row%0d ch%0d: pixel %0d actual %h required %h", k/3, k%3,
                 first_diff(obs[k], req), obs[k][8*first_diff(obs[k], req) +: 8],
                 req[8*first_diff(obs[k], req) +: 8]);
      end
    end
  endtask

  task automatic test_stall();
    logic [OW-1:0] req;
    apply(1'b1, 1'b1, 9'd3, IW'(7), IW'(7), IW'(7));
    apply(1'b1, 1'b1, 9'd4, IW'(240), IW'(240), IW'(240));
    for (int k = 0; k < 9; k++) begin
      req = OW'((k/3 + 1) * 256);
      vectors++;
      if (obs[k] !== req) begin
        miscompares++;
        $display("FAIL stall_hold row%0d ch%0d: pixel %0d actual %h required %h", k/3, k%3,
                 first_diff(obs[k], req), obs[k][8*first_diff(obs[k], req) +: 8],
                 req[8*first_diff(obs[k], req) +: 8]);
      end
    end
  endtask

  task automatic test_bottom_flush();
    logic [IW-1:0] x414 [3];
    logic [OW-1:0] req;
    for (int ch = 0; ch < 3; ch++) x414[ch] = rand_row();
    apply(1'b1, 1'b0, 9'd414, x414[0], x414[1], x414[2]);
    apply(1'b1, 1'b0, 9'd415, IW'(5), IW'(5), IW'(5));
    apply(1'b1, 1'b0, 9'd416, rand_row(), rand_row(), rand_row());
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 9; k++) begin
        req = (k/3 == 0) ? pad_row(x414[k%3]) : (k/3 == 1) ? OW'(1280) : '0;
        vectors++;
        if (obs[k] !== req) begin
          miscompares++;
          $display("FAIL bottom_flush%0d row%0d ch%0d: pixel %0d actual %h required %h", pass,
                   k/3, k%3, first_diff(obs[k], req), obs[k][8*first_diff(obs[k], req) +: 8],
                   req[8*first_diff(obs[k], req) +: 8]);
        end
      end
      // Second pass: index 417 must leave the flushed window alone.
      if (pass == 0) apply(1'b1, 1'b0, 9'd417, rand_row(), rand_row(), rand_row());
    end
  endtask

  task automatic test_edge_pixel();
    logic [IW-1:0] x [3];
    for (int ch = 0; ch < 3; ch++) begin
      x[ch] = rand_row();
      x[ch][7:0] = 8'hAA;
      x[ch][3327:3320] = 8'h55;
    end
    apply(1'b1, 1'b0, 9'd0, x[0], x[1], x[2]);
    for (int ch = 0; ch < 3; ch++) begin
      vectors++;
      if (obs[6+ch][15:8] !== 8'hAA || obs[6+ch][3335:3328] !== 8'h55 ||
          obs[6+ch][7:0] !== 8'h00 || obs[6+ch][3343:3336] !== 8'h00) begin
        miscompares++;
        $display("FAIL edge_pixel ch%0d: actual first=%h p1=%h p416=%h last=%h required 00 aa 55 00",
                 ch, obs[6+ch][7:0], obs[6+ch][15:8], obs[6+ch][3335:3328], obs[6+ch][3343:3336]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [IW-1:0] x [3];
    logic [OW-1:0] req;
    apply(1'b1, 1'b0, 9'd0, rand_row(), rand_row(), rand_row());
    apply(1'b1, 1'b0, 9'd1, rand_row(), rand_row(), rand_row());
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_clear();
    req = '0;
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (obs[k] !== req) begin
        miscompares++;
        $display("FAIL mid_reset_async row%0d ch%0d: pixel %0d actual %h required %h", k/3, k%3,
                 first_diff(obs[k], req), obs[k][8*first_diff(obs[k], req) +: 8],
                 req[8*first_diff(obs[k], req) +: 8]);
      end
    end
    #2 reset = 1'b1;
    for (int ch = 0; ch < 3; ch++) x[ch] = rand_row();
    apply(1'b1, 1'b0, 9'd0, x[0], x[1], x[2]);
    for (int k = 0; k < 9; k++) begin
      req = (k/3 == 2) ? pad_row(x[k%3]) : '0;
      vectors++;
      if (obs[k] !== req) begin
        miscompares++;
        $display("FAIL mid_reset_restart row%0d ch%0d: pixel %0d actual %h required %h", k/3, k%3,
                 first_diff(obs[k], req), obs[k][8*first_diff(obs[k], req) +: 8],
                 req[8*first_diff(obs[k], req) +: 8]);
      end
    end
  endtask

  task automatic test_random();
    logic       e, w;
    logic [8:0] c;
    for (int n = 0; n < 150; n++) begin
      e = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom_range(1, 420));
      apply(e, w, c, rand_row(), rand_row(), rand_row());
      for (int k = 0; k < 9; k++) begin
        vectors++;
        if (obs[k] !== win[k%3][k/3]) begin
          miscompares++;
          $display("FAIL random%0d row%0d ch%0d: pixel %0d actual %h required %h", n, k/3, k%3,
                   first_diff(obs[k], win[k%3][k/3]),
                   obs[k][8*first_diff(obs[k], win[k%3][k/3]) +: 8],
                   win[k%3][k/3][8*first_diff(obs[k], win[k%3][k/3]) +: 8]);
        end
      end
`ifdef PADDING_VALID_EN
      vectors++;
      if (win_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL random%0d win_valid: actual %b required %b", n, win_valid, exp_valid);
      end
`endif
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_row_sequence();
    test_stall();
    test_bottom_flush();
    test_edge_pixel();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/padding_top_core.md
PADDING_TOP_CORE -- requirements
Module: padding_top

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port `en`, input, 1 bit: the input row on R/G/B_input is presented this cycle.
REQ-004 SHALL have port `wait_en`, input, 1 bit: downstream stall; all state holds while high.
REQ-005 SHALL have port `count`, input, 9 bits: row index of the presented row; 0..415 = image rows, 416 = bottom-pad flush.
REQ-006 SHALL have ports `R_input`, `G_input`, `B_input`, input, 3328 bits each: one 416-pixel row, 8 bits per pixel; pixel i sits at bits [8i+7:8i].
REQ-007 SHALL have ports `R_row0`, `G_row0`, `B_row0`, output, 3344 bits each: oldest (top) row of the 3-row window, 418 pixels.
REQ-008 SHALL have ports `R_row1`, `G_row1`, `B_row1`, output, 3344 bits each: middle row of the window.
REQ-009 SHALL have ports `R_row2`, `G_row2`, `B_row2`, output, 3344 bits each: newest (bottom) row of the window.
REQ-010 SHALL have port `win_valid`, output, 1 bit, only when PADDING_VALID_EN is defined: the window is centred on a real image row.

Function
REQ-011 SHALL form each padded row as {8'h00, X_input, 8'h00}: a zero pixel at index 0 and at index 417; input pixel i maps to padded pixel i+1.
REQ-012 SHALL hold all registers when wait_en=1, regardless of en or count (wait_en has priority over en).
REQ-013 SHALL hold all registers when en=0.
REQ-014 When en=1, wait_en=0 and count=0, SHALL, per channel, clear row0 and row1 to zero (top padding) and load the padded input into row2.
REQ-015 When en=1, wait_en=0 and 1<=count<=415, SHALL shift per channel: row0<=row1, row1<=row2, row2<=padded input.
REQ-016 When en=1, wait_en=0 and count=416, SHALL shift with a zero row: row0<=row1, row1<=row2, row2<=0 (bottom padding); X_input is ignored.
REQ-017 When en=1, wait_en=0 and count>=417, SHALL hold all registers.
REQ-018 SHALL update all outputs one clock after the accepting edge; outputs are registered with no combinational path from inputs.
REQ-019 SHALL treat the R, G and B channels identically and in lockstep.
REQ-020 SHALL treat row content as opaque 8-bit data, with no arithmetic, saturation or reordering.

Reset
REQ-021 While reset=0, SHALL asynchronously force all nine row outputs to zero (and win_valid to 0 when present).
REQ-022 Reset asserted mid-frame SHALL discard the window; the next accepted count=0 restarts normally.

Configuration
REQ-023 With PADDING_VALID_EN defined, SHALL include win_valid, set to 1 after an accepted shift with 1<=count<=416 and to 0 after an accepted count=0 load; it holds during stall or ignored cycles.
REQ-024 Without PADDING_VALID_EN, SHALL omit the win_valid port and its register; the row datapath is unchanged.

Verification
REQ-025 Reset scenario: reset=0 with nonzero inputs -> all rows read 0; release reset with en=0 -> outputs stay 0.
REQ-026 Row-sequence scenario: en=1, wait_en=0, count=0/1/2 with inputs 1/2/3 -> after the third edge row0=256, row1=512, row2=768 (as 3344-bit values), identical on R/G/B.
REQ-027 Stall scenario: after REQ-026, wait_en=1 with count=3,4 and inputs 7,240 -> rows stay 256/512/768.
REQ-028 Bottom-flush scenario: load count=414, then 415 (input 5), then count=416 -> row0=row414 padded, row1=1280, row2=0; count=417 then holds.
REQ-029 Edge-pixel scenario: input pixel 0=0xAA and pixel 415=0x55 at count=0 -> row2[15:8]=0xAA, row2[3335:3328]=0x55, row2[7:0]=0 and row2[3343:3336]=0.
REQ-030 Mid-frame reset scenario: pulse reset low mid-frame -> outputs immediately 0; a subsequent count=0 load gives row0=row1=0 and row2 = padded input.
